spi_master_arbiter: RTL
=======================

// Module: spi_master_arbiter
// PURPOSE
//  Shares one SPI master engine (CS/SCK generator, delay stage, shifter) between NUM_REQ clients.
//  Arbitrates round-robin, loads the winner's mode (cpol/cpha) and tx word into the engine, and selects its chip select.
//  Returns rx data and a done pulse, then enforces a CS-deasserted guard gap before the next transfer.
//  Sits between client FSMs and the SPI master core, in the system clock domain.
// PARAMETERS
//  NUM_REQ       4     number of requesters (2..8)
//  DATA_W        8     SPI word width
//  GAP_CLKS      4     clk cycles of CS-idle between transfers (0 allowed)
//  TIMEOUT_CLKS  1024  WAIT watchdog limit, used only with SPI_ARB_TIMEOUT_EN
// PORTS
//  clk          in   1               system clock
//  rst_n        in   1               asynchronous reset, active-low
//  req          in   NUM_REQ         transfer request per client, level
//  req_cpol     in   NUM_REQ         per-client SCK idle level
//  req_cpha     in   NUM_REQ         per-client sample phase
//  req_tx_data  in   NUM_REQ*DATA_W  per-client tx word, client i at [i*DATA_W +: DATA_W]
//  gnt          out  NUM_REQ         one-hot grant
//  req_done     out  NUM_REQ         one-cycle completion pulse to the granted client
//  req_err      out  1               qualifies req_done: transfer aborted
//  req_rx_data  out  DATA_W          rx word, valid with req_done, held until next completion
//  busy         out  1               high in any state except IDLE
//  m_start      out  1               one-cycle start pulse to the SPI core
//  m_cpol       out  1               mode to core, held between STARTs
//  m_cpha       out  1               mode to core, held between STARTs
//  m_tx_data    out  DATA_W          tx word to core, held between STARTs
//  m_cs_sel     out  NUM_REQ         one-hot CS select, 0 when no client is granted
//  m_abort      out  1               one-cycle abort pulse to the core
//  m_done       in   1               core completion pulse
//  m_rx_data    in   DATA_W          core rx word, valid with m_done
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. RR pointer = NUM_REQ-1, so client 0 wins first.
//  States and transitions:
//   IDLE: if |req, the winner is the first set bit searching from ptr+1 upward with wrap. ptr<=winner, go to START.
//   START (1 cycle): gnt, m_cs_sel = onehot(winner); m_start=1. Latch m_cpol/m_cpha/m_tx_data. Go to WAIT.
//   WAIT: gnt and m_cs_sel held. On m_done: capture m_rx_data into req_rx_data, pulse req_done[winner], go to GAP.
//   GAP: gnt=0, m_cs_sel=0. Count GAP_CLKS cycles, then go to IDLE. If GAP_CLKS==0, go straight to IDLE.
//  Timing: req sampled in IDLE at cycle t -> m_start and gnt at t+1. m_done at d -> req_done at d+1.
//   Next m_start is no earlier than d+GAP_CLKS+2.
//  Requester rules:
//   Client holds req, cfg and data until gnt. Dropping req after START does not abort the transfer.
//   Client deasserts req on req_done for a single transfer. Still high at IDLE = new request.
//  Boundaries:
//   m_done outside WAIT is ignored.
//   Only one client is granted at a time. A single requester is re-granted every round.
//   Reset mid-transfer drops state at once, with no done pulse. The SPI core shares rst_n.
//   m_cpol/m_cpha change only in START, so the SCK idle level is stable during GAP and IDLE.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//   WAIT counts cycles from START.
//   If TIMEOUT_CLKS is reached with no m_done: pulse m_abort for 1 cycle, pulse req_done[winner] with req_err=1,
//    leave req_rx_data unchanged, go to GAP.
//   m_done and timeout in the same cycle: m_done wins.
//  SPI_ARB_TIMEOUT_EN undefined: no counter; m_abort and req_err tied 0; WAIT waits forever.
// TESTING
//  T1: req=0001, tx0=0xA5, cpol/cpha=0/0. Core returns 0x3C.
//   -> m_start 1 cycle after req; m_cs_sel=0001; req_done[0] with rx=0x3C; busy low GAP_CLKS+1 cycles after done.
//  T2: req=1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3; each m_tx_data matches the granted slot.
//  T3: client1 cpol=1,cpha=1; client2 cpol=0,cpha=1; both requesting.
//   -> m_cpol/m_cpha = 1/1 then 0/1, changing only on m_start cycles.
//  T4: m_done pulsed in IDLE and in GAP -> no req_done, state unchanged.
//  T5: rst_n low during WAIT with gnt=0100 -> all outputs 0 immediately; after release, req=0100 is granted again.
//  T6: SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CLKS=16, core silent.
//   -> m_abort and req_done with req_err=1 at START+16; the next request proceeds normally.

Source files
------------

// File: rtl/spi_master_arbiter_if.sv
// Bus between the arbiter (master side) and the shared SPI master core (slave side).
interface spi_master_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic               m_start;
  logic               m_cpol;
  logic               m_cpha;
  logic [DATA_W-1:0]  m_tx_data;
  logic [NUM_REQ-1:0] m_cs_sel;
  logic               m_abort;
  logic               m_done;
  logic [DATA_W-1:0]  m_rx_data;

  modport master (
    output m_start, m_cpol, m_cpha, m_tx_data, m_cs_sel, m_abort,
    input  m_done, m_rx_data
  );

  modport slave (
    input  m_start, m_cpol, m_cpha, m_tx_data, m_cs_sel, m_abort,
    output m_done, m_rx_data
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master core between NUM_REQ clients, with CS guard gap.
// Optional WAIT watchdog with core abort: define SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CLKS     = 4,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_cpol,
  input  logic [NUM_REQ-1:0]        req_cpha,
  input  logic [NUM_REQ*DATA_W-1:0] req_tx_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [DATA_W-1:0]         req_rx_data,
  output logic                      busy,
  spi_master_arbiter_if.master      m_bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = $clog2(GAP_CLKS + 2);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CLKS == 0) ? '0 : GAP_W'(GAP_CLKS - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CLKS < 0 || TIMEOUT_CLKS < 2) begin : g_param_check
    $error("spi_master_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_cand;
  logic               w_found;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_finish;
  logic               w_timeout;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [NUM_REQ-1:0] r_req_done;
  logic [DATA_W-1:0]  r_rx_data;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_cpol;
  logic               r_cpha;

  // r_ptr doubles as the current winner from START until the next IDLE.
  assign w_onehot = NUM_REQ'(1) << r_ptr;

  always_comb begin
    w_winner = r_ptr;
    w_cand   = r_ptr;
    w_found  = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((32'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    w_finish        = 1'b0;
    gnt             = '0;
    busy            = (r_state != S_IDLE);
    m_bus.m_start   = 1'b0;
    m_bus.m_cs_sel  = '0;
    case (r_state)
      S_IDLE: begin
        if (|req) w_next = S_START;
      end
      S_START: begin
        gnt            = w_onehot;
        m_bus.m_cs_sel = w_onehot;
        m_bus.m_start  = 1'b1;
        w_next         = S_WAIT;
      end
      S_WAIT: begin
        gnt            = w_onehot;
        m_bus.m_cs_sel = w_onehot;
        if (m_bus.m_done || w_timeout) begin
          w_finish = 1'b1;
          if (GAP_CLKS == 0) w_next = S_IDLE;
          else               w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= IDX_W'(NUM_REQ - 1);
      r_gap_cnt  <= '0;
      r_req_done <= '0;
      r_rx_data  <= '0;
      r_tx_data  <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_req_done <= '0;
      // Mode and data load on the edge into START so they are valid with m_start.
      if (r_state == S_IDLE && |req) begin
        r_ptr     <= w_winner;
        r_cpol    <= req_cpol[w_winner];
        r_cpha    <= req_cpha[w_winner];
        r_tx_data <= req_tx_data[w_winner*DATA_W +: DATA_W];
      end
      if (w_finish) begin
        r_req_done <= w_onehot;
        if (m_bus.m_done) r_rx_data <= m_bus.m_rx_data;
      end
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  assign req_done        = r_req_done;
  assign req_rx_data     = r_rx_data;
  assign m_bus.m_cpol    = r_cpol;
  assign m_bus.m_cpha    = r_cpha;
  assign m_bus.m_tx_data = r_tx_data;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_abort;
  logic            r_req_err;

  // Counter equals cycles elapsed since START while in WAIT.
  assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TO_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt  <= '0;
      r_abort   <= 1'b0;
      r_req_err <= 1'b0;
    end else begin
      r_abort   <= w_timeout && !m_bus.m_done;
      r_req_err <= w_timeout && !m_bus.m_done;
      if (r_state == S_START)     r_to_cnt <= TO_W'(1);
      else if (r_state == S_WAIT) r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign m_bus.m_abort = r_abort;
  assign req_err       = r_req_err;
`else
  assign w_timeout     = 1'b0;
  assign m_bus.m_abort = 1'b0;
  assign req_err       = 1'b0;
`endif

endmodule
